// File: rtl/debug_mem_arb.sv
// Round-robin arbiter that shares one valid/ready memory port between the debug
// module's abstract-command path (A) and its system-bus path (S), with a response timeout.
module debug_mem_arb #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            A_REQ,
  input  logic            A_WR,
  input  logic [AW-1:0]   A_AD,
  input  logic [DW/8-1:0] A_ST,
  input  logic [DW-1:0]   A_WD,
  output logic            A_ACK,
  output logic            A_ERR,
  output logic [DW-1:0]   A_RD,
  input  logic            S_REQ,
  input  logic            S_WR,
  input  logic [AW-1:0]   S_AD,
  input  logic [DW/8-1:0] S_ST,
  input  logic [DW-1:0]   S_WD,
  output logic            S_ACK,
  output logic            S_ERR,
  output logic [DW-1:0]   S_RD,
  output logic            M_VALID,
  input  logic            M_READY,
  output logic            M_WR,
  output logic [AW-1:0]   M_AD,
  output logic [DW/8-1:0] M_ST,
  output logic [DW-1:0]   M_WD,
  input  logic            M_RVALID,
  input  logic [DW-1:0]   M_RDATA
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    RESP,
    DONE
  } state_t;

  state_t          state_q;
  logic            ptr_q;     // 0: A has priority, 1: S has priority
  logic            win_q;     // 0: A owns the transaction, 1: S
  logic            wr_q;
  logic [CW-1:0]   cnt_q;
  logic            m_valid_q;
  logic            m_wr_q;
  logic [AW-1:0]   m_ad_q;
  logic [SW-1:0]   m_st_q;
  logic [DW-1:0]   m_wd_q;
  logic            a_ack_q;
  logic            a_err_q;
  logic [DW-1:0]   a_rd_q;
  logic            s_ack_q;
  logic            s_err_q;
  logic [DW-1:0]   s_rd_q;

  logic            grant_s_d;
  logic            fin_d;
  logic            fin_err_d;
  logic [DW-1:0]   fin_rd_d;

  always_comb begin
    grant_s_d = S_REQ;
    if (A_REQ && S_REQ) begin
      grant_s_d = ptr_q;
    end
  end

  // A timeout wins over an address handshake in the same cycle; a response does not.
  always_comb begin
    fin_err_d = 1'b0;
    fin_d     = 1'b0;
    if (state_q == ADDR) begin
      fin_err_d = (cnt_q == CNT_LAST);
      fin_d     = fin_err_d;
    end else if (state_q == RESP) begin
      fin_err_d = !M_RVALID && (cnt_q == CNT_LAST);
      fin_d     = M_RVALID || fin_err_d;
    end
    fin_rd_d = (fin_err_d || wr_q) ? '0 : M_RDATA;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b0;
      win_q     <= 1'b0;
      wr_q      <= 1'b0;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_wr_q    <= 1'b0;
      m_ad_q    <= '0;
      m_st_q    <= '0;
      m_wd_q    <= '0;
      a_ack_q   <= 1'b0;
      a_err_q   <= 1'b0;
      a_rd_q    <= '0;
      s_ack_q   <= 1'b0;
      s_err_q   <= 1'b0;
      s_rd_q    <= '0;
    end else begin
      a_ack_q <= 1'b0;
      a_err_q <= 1'b0;
      a_rd_q  <= '0;
      s_ack_q <= 1'b0;
      s_err_q <= 1'b0;
      s_rd_q  <= '0;

      case (state_q)
        IDLE: begin
          if (A_REQ || S_REQ) begin
            win_q     <= grant_s_d;
            ptr_q     <= ~grant_s_d;
            wr_q      <= grant_s_d ? S_WR : A_WR;
            cnt_q     <= '0;
            m_valid_q <= 1'b1;
            m_wr_q    <= grant_s_d ? S_WR : A_WR;
            m_ad_q    <= grant_s_d ? S_AD : A_AD;
            m_st_q    <= grant_s_d ? S_ST : A_ST;
            m_wd_q    <= grant_s_d ? S_WD : A_WD;
            state_q   <= ADDR;
          end
        end
        ADDR, RESP: begin
          cnt_q <= cnt_q + CW'(1);
          if (fin_d || (state_q == ADDR && M_READY)) begin
            m_valid_q <= 1'b0;
            m_wr_q    <= 1'b0;
            m_ad_q    <= '0;
            m_st_q    <= '0;
            m_wd_q    <= '0;
          end
          if (fin_d) begin
            state_q <= DONE;
            if (win_q) begin
              s_ack_q <= 1'b1;
              s_err_q <= fin_err_d;
              s_rd_q  <= fin_rd_d;
            end else begin
              a_ack_q <= 1'b1;
              a_err_q <= fin_err_d;
              a_rd_q  <= fin_rd_d;
            end
          end else if (state_q == ADDR && M_READY) begin
            state_q <= RESP;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign M_VALID = m_valid_q;
  assign M_WR    = m_wr_q;
  assign M_AD    = m_ad_q;
  assign M_ST    = m_st_q;
  assign M_WD    = m_wd_q;
  assign A_ACK   = a_ack_q;
  assign A_ERR   = a_err_q;
  assign A_RD    = a_rd_q;
  assign S_ACK   = s_ack_q;
  assign S_ERR   = s_err_q;
  assign S_RD    = s_rd_q;

endmodule

// File: tb/tb_debug_mem_arb.sv
// Directed bench for debug_mem_arb: vector table of single transactions plus
// hand-written sequences for stalls, timeout, reset and streaming.
module tb_debug_mem_arb;

  logic        CLK = 1'b0;
  logic        RST;
  logic        A_REQ, A_WR, S_REQ, S_WR;
  logic [31:0] A_AD, A_WD, S_AD, S_WD;
  logic [3:0]  A_ST, S_ST;
  logic        A_ACK, A_ERR, S_ACK, S_ERR;
  logic [31:0] A_RD, S_RD;
  logic        M_VALID, M_READY, M_WR, M_RVALID;
  logic [31:0] M_AD, M_WD, M_RDATA;
  logic [3:0]  M_ST;

  int n_tests = 0;
  int n_fail  = 0;

  debug_mem_arb #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
    .CLK(CLK), .RST(RST),
    .A_REQ(A_REQ), .A_WR(A_WR), .A_AD(A_AD), .A_ST(A_ST), .A_WD(A_WD),
    .A_ACK(A_ACK), .A_ERR(A_ERR), .A_RD(A_RD),
    .S_REQ(S_REQ), .S_WR(S_WR), .S_AD(S_AD), .S_ST(S_ST), .S_WD(S_WD),
    .S_ACK(S_ACK), .S_ERR(S_ERR), .S_RD(S_RD),
    .M_VALID(M_VALID), .M_READY(M_READY), .M_WR(M_WR), .M_AD(M_AD),
    .M_ST(M_ST), .M_WD(M_WD), .M_RVALID(M_RVALID), .M_RDATA(M_RDATA)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        a_req, s_req, a_wr, s_wr;
    logic [31:0] a_ad, s_ad;
    logic [3:0]  a_st, s_st;
    logic [31:0] a_wd, s_wd, rdata;
    logic        exp_a, exp_s, exp_wr;
    logic [31:0] exp_ad;
    logic [3:0]  exp_st;
    logic [31:0] exp_wd, exp_rd;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Three edges from the IDLE cycle that samples the request to the DONE cycle.
  task automatic serve(input string nm, input logic ea, input logic es, input logic [31:0] erd);
    step();
    step();
    step();
    chk({nm, "_a_ack"}, 32'(A_ACK), 32'(ea));
    chk({nm, "_s_ack"}, 32'(S_ACK), 32'(es));
    chk({nm, "_a_rd"}, A_RD, ea ? erd : 32'h0);
    chk({nm, "_s_rd"}, S_RD, es ? erd : 32'h0);
    chk({nm, "_err"}, 32'({A_ERR, S_ERR}), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sdat [3];
    int  n;
    logic got;

    // Pointer starts at A; expected winners follow the pointer flips by hand.
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0,   4'hF, 4'h0, 32'h0, 32'h0,
                32'h12345678, 1'b1, 1'b0, 1'b0, 32'h100, 4'hF, 32'h0, 32'h12345678};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h200, 4'h0, 4'hF, 32'h0, 32'h0,
                32'hA5A55A5A, 1'b0, 1'b1, 1'b0, 32'h200, 4'hF, 32'h0, 32'hA5A55A5A};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h300, 32'h400, 4'h3, 4'hF, 32'h11112222, 32'h0,
                32'hFFFF0000, 1'b1, 1'b0, 1'b1, 32'h300, 4'h3, 32'h11112222, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h300, 32'h400, 4'h3, 4'hF, 32'h11112222, 32'h0,
                32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'h400, 4'hF, 32'h0, 32'hDEADBEEF};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,   32'h500, 4'h0, 4'hC, 32'h0, 32'h0BADF00D,
                32'h77777777, 1'b0, 1'b1, 1'b1, 32'h500, 4'hC, 32'h0BADF00D, 32'h0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h600, 32'h504, 4'hF, 4'h1, 32'h0, 32'h000000AA,
                32'h55AA55AA, 1'b1, 1'b0, 1'b0, 32'h600, 4'hF, 32'h0, 32'h55AA55AA};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h700, 32'h0,   4'hF, 4'h0, 32'h0, 32'h0,
                32'h0C0FFEE0, 1'b1, 1'b0, 1'b0, 32'h700, 4'hF, 32'h0, 32'h0C0FFEE0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h704, 32'h800, 4'hF, 4'hF, 32'h0, 32'h0,
                32'h01020304, 1'b0, 1'b1, 1'b0, 32'h800, 4'hF, 32'h0, 32'h01020304};

    RST = 1'b1;
    A_REQ = 1'b0; A_WR = 1'b0; A_AD = '0; A_ST = '0; A_WD = '0;
    S_REQ = 1'b0; S_WR = 1'b0; S_AD = '0; S_ST = '0; S_WD = '0;
    M_READY = 1'b0; M_RVALID = 1'b0; M_RDATA = '0;

    step();
    step();
    chk("rst_mvalid", 32'(M_VALID), 32'h0);
    chk("rst_mad", M_AD, 32'h0);
    chk("rst_acks", 32'({A_ACK, S_ACK, A_ERR, S_ERR}), 32'h0);
    chk("rst_rd", A_RD | S_RD, 32'h0);
    RST = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      A_REQ = vecs[i].a_req; A_WR = vecs[i].a_wr; A_AD = vecs[i].a_ad;
      A_ST = vecs[i].a_st;   A_WD = vecs[i].a_wd;
      S_REQ = vecs[i].s_req; S_WR = vecs[i].s_wr; S_AD = vecs[i].s_ad;
      S_ST = vecs[i].s_st;   S_WD = vecs[i].s_wd;
      M_READY = 1'b1; M_RVALID = 1'b1; M_RDATA = vecs[i].rdata;
      step();
      chk($sformatf("v%0d_mvalid", i), 32'(M_VALID), 32'h1);
      chk($sformatf("v%0d_mwr", i), 32'(M_WR), 32'(vecs[i].exp_wr));
      chk($sformatf("v%0d_mad", i), M_AD, vecs[i].exp_ad);
      chk($sformatf("v%0d_mst", i), 32'(M_ST), 32'(vecs[i].exp_st));
      chk($sformatf("v%0d_mwd", i), M_WD, vecs[i].exp_wd);
      step();
      chk($sformatf("v%0d_resp_mvalid", i), 32'(M_VALID), 32'h0);
      chk($sformatf("v%0d_resp_ack", i), 32'({A_ACK, S_ACK}), 32'h0);
      step();
      chk($sformatf("v%0d_a_ack", i), 32'(A_ACK), 32'(vecs[i].exp_a));
      chk($sformatf("v%0d_s_ack", i), 32'(S_ACK), 32'(vecs[i].exp_s));
      chk($sformatf("v%0d_a_rd", i), A_RD, vecs[i].exp_a ? vecs[i].exp_rd : 32'h0);
      chk($sformatf("v%0d_s_rd", i), S_RD, vecs[i].exp_s ? vecs[i].exp_rd : 32'h0);
      chk($sformatf("v%0d_err", i), 32'({A_ERR, S_ERR}), 32'h0);
      A_REQ = 1'b0; S_REQ = 1'b0;
      step();
      chk($sformatf("v%0d_idle_ack", i), 32'({A_ACK, S_ACK}), 32'h0);
    end

    // S write held off by M_READY for five cycles.
    M_READY = 1'b0; M_RVALID = 1'b0; M_RDATA = 32'h99;
    S_REQ = 1'b1; S_WR = 1'b1; S_AD = 32'h2000; S_WD = 32'hCAFEF00D; S_ST = 4'hF;
    step();
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("stall%0d_mvalid", k), 32'(M_VALID), 32'h1);
      chk($sformatf("stall%0d_fields", k), M_AD ^ M_WD, 32'h2000 ^ 32'hCAFEF00D);
      chk($sformatf("stall%0d_wrst", k), 32'({M_WR, M_ST}), 32'h1F);
      if (k == 5) M_READY = 1'b1;
      step();
    end
    chk("stall_resp_mvalid", 32'(M_VALID), 32'h0);
    chk("stall_resp_ack", 32'(S_ACK), 32'h0);
    M_READY = 1'b0; M_RVALID = 1'b1;
    step();
    chk("stall_s_ack", 32'(S_ACK), 32'h1);
    chk("stall_s_err", 32'(S_ERR), 32'h0);
    chk("stall_s_rd", S_RD, 32'h0);
    chk("stall_a_ack", 32'(A_ACK), 32'h0);
    S_REQ = 1'b0; M_RVALID = 1'b0; S_WR = 1'b0;
    step();

    // A read with no response: error ack 17 edges after the request is sampled.
    A_REQ = 1'b1; A_WR = 1'b0; A_AD = 32'h100;
    M_READY = 1'b1; M_RVALID = 1'b0; M_RDATA = 32'hFFFFFFFF;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      step();
      n++;
      if (A_ACK) got = 1'b1;
    end
    chk("to_latency", 32'(n), 32'd17);
    chk("to_a_err", 32'(A_ERR), 32'h1);
    chk("to_a_rd", A_RD, 32'h0);
    chk("to_s_ack", 32'(S_ACK), 32'h0);
    A_REQ = 1'b0;
    step();
    M_RVALID = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("stray%0d_ack", k), 32'({A_ACK, S_ACK, M_VALID}), 32'h0);
    end
    M_RVALID = 1'b0;

    // Reset while A holds the address phase; the pointer must return to A.
    A_REQ = 1'b1; A_AD = 32'h900; M_READY = 1'b0;
    step();
    chk("pre_rst_mvalid", 32'(M_VALID), 32'h1);
    S_REQ = 1'b1; S_WR = 1'b0; S_AD = 32'hA00;
    #2;
    RST = 1'b1;
    #1;
    chk("async_rst_mvalid", 32'(M_VALID), 32'h0);
    chk("async_rst_mad", M_AD, 32'h0);
    chk("async_rst_ack", 32'({A_ACK, S_ACK}), 32'h0);
    step();
    RST = 1'b0;
    M_READY = 1'b1; M_RVALID = 1'b1; M_RDATA = 32'h600DD00D;
    serve("post_rst_a", 1'b1, 1'b0, 32'h600DD00D);
    A_REQ = 1'b0; M_RDATA = 32'h5EC0D000;
    step();
    serve("post_rst_s", 1'b0, 1'b1, 32'h5EC0D000);
    S_REQ = 1'b0;
    step();

    // S streams three reads on its own.
    sdat[0] = 32'h10000001; sdat[1] = 32'h20000002; sdat[2] = 32'h30000003;
    for (int j = 0; j < 3; j++) begin
      S_REQ = 1'b1; S_AD = 32'h3000 + 32'(j * 4); M_RDATA = sdat[j];
      serve($sformatf("stream%0d", j), 1'b0, 1'b1, sdat[j]);
      S_REQ = 1'b0;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
